sargantana_icache_tag_ctrl: RTL
===============================

Name: sargantana_icache_tag_ctrl

Overview:
Tag-lookup and refill sequencer that sits directly in front of the per-way tag memories of the Sargantana I-cache.
- Accepts a lookup (set index + tag) and issues a read to all ways.
- Compares returned tags and valid bits, and reports hit or miss with the hitting way.
- On a miss, waits for refill completion, then writes the tag with vbit=1 into a selected victim way.
- Forwards flush to the ways and aborts any in-flight operation.

Parameters:
NUM_WAYS, 4, number of tag ways (power of 2, 2..8)
TAG_WIDHT, 20, tag width in bits (package constant)
TAG_ADDR_WIDHT, 6, set-index width in bits (package constant)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
lookup_valid_i  in  1  lookup request
lookup_ready_o  out  1  controller can accept a lookup
lookup_idx_i  in  TAG_ADDR_WIDHT  set index
lookup_tag_i  in  TAG_WIDHT  tag to compare
resp_valid_o  out  1  one-cycle response pulse
resp_hit_o  out  1  1 = hit, 0 = miss
resp_way_o  out  NUM_WAYS  one-hot hitting way on hit; one-hot victim way on miss
refill_valid_i  in  1  line data for the outstanding miss has been written
refill_ready_o  out  1  controller is waiting for refill
flush_i  in  1  invalidate the whole cache
tag_req_o  out  NUM_WAYS  per-way request
tag_we_o  out  1  write enable, common to all ways
tag_vbit_o  out  1  valid bit to write
tag_flush_o  out  1  flush to all ways
tag_addr_o  out  TAG_ADDR_WIDHT  way address
tag_data_o  out  TAG_WIDHT  tag write data
tag_rdata_i  in  NUM_WAYS*TAG_WIDHT  per-way read tag; way w occupies bits [w*TAG_WIDHT +: TAG_WIDHT]
tag_vbit_i  in  NUM_WAYS  per-way read valid bit

Behaviour:
- Tag ways have 1-cycle read latency, synchronous write and synchronous flush. Their outputs hold stale data when not read, so they are sampled only in COMPARE.
- Reset (asynchronous, any time): state=IDLE, round-robin pointer rr=0, latched idx/tag=0, resp_valid_o=0, resp_hit_o=0, resp_way_o=0. Combinational outputs follow the IDLE decode. Reset mid-operation drops the operation; no write is ever issued.
- FSM states: IDLE, COMPARE, MISS, WRITE.
- IDLE:
  - lookup_ready_o = !flush_i.
  - On lookup_valid_i & lookup_ready_o (cycle N): tag_req_o = all ones, tag_we_o=0, tag_addr_o=lookup_idx_i; latch idx and tag; go to COMPARE.
- COMPARE (cycle N+1):
  - hit[w] = tag_vbit_i[w] & (tag_rdata_i[w] == latched tag).
  - On any hit: register resp_valid_o=1, resp_hit_o=1, resp_way_o = lowest-index hit (visible at N+2); go to IDLE. Multiple hits resolve to the lowest index.
  - On miss: victim = lowest-index way with vbit=0; if all ways are valid, victim = one-hot(rr). Register resp_valid_o=1, resp_hit_o=0, resp_way_o=victim; latch victim; go to MISS.
- MISS:
  - refill_ready_o = !flush_i.
  - On refill_valid_i & refill_ready_o, go to WRITE.
- WRITE (exactly 1 cycle):
  - tag_req_o = victim, tag_we_o=1, tag_vbit_o=1, tag_addr_o = latched idx, tag_data_o = latched tag.
  - If the victim was chosen by rr, rr = rr+1 mod NUM_WAYS (wraps from NUM_WAYS-1 to 0).
  - Go to IDLE.
- resp_valid_o is high for exactly one cycle per accepted lookup, unless the lookup is aborted by a flush.
- Flush:
  - tag_flush_o = flush_i, combinational, same cycle.
  - flush_i in any state: next state=IDLE, rr=0, no tag request that cycle (tag_req_o=0).
  - A flush in COMPARE suppresses the response. A flush in MISS or WRITE cancels the write.
  - Flush wins over a simultaneous lookup_valid_i or refill_valid_i.
- refill_valid_i outside MISS is ignored.
- Idle defaults: tag_req_o=0, tag_we_o=0, tag_vbit_o=0, tag_addr_o = lookup_idx_i (in IDLE) or latched idx (other states), tag_data_o = latched tag.

Decomposition:
- Package sargantana_icache_pkg holds TAG_WIDHT, TAG_ADDR_WIDHT, ICACHE_N_WAY, and a tag_ctrl_state_t enum {IDLE, COMPARE, MISS, WRITE}.
- One sub-module: sargantana_icache_victim_sel (combinational first-invalid priority encode, rr fallback, one-hot output).

Test Plan:
- Reset, then write tag 0x12345 at idx 5 way 2 via the miss path; lookup idx 5 tag 0x12345 -> resp at N+2, hit=1, way=4'b0100, no write.
- Empty cache, lookup idx 3 tag 0xABCDE -> miss, way=4'b0001. refill_valid_i 4 cycles later -> single WRITE cycle: req=0001, we=1, vbit=1, addr=3, data=0xABCDE.
- All 4 ways valid at idx 7 with distinct tags, 5 successive misses at idx 7 -> victims 0001, 0010, 0100, 1000, 0001 (rr wrap).
- flush_i asserted in MISS together with refill_valid_i -> tag_flush_o=1 that cycle, no write, state IDLE. A following lookup of the same tag -> miss with victim 0001.
- flush_i in COMPARE -> no resp_valid_o pulse. flush_i with lookup_valid_i in IDLE -> lookup_ready_o=0, no tag_req_o.
- rstn_i pulsed low asynchronously (mid-cycle) while in WRITE -> tag_we_o=0 immediately, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// Shared constants and state encoding for the Sargantana I-cache tag controller.
package sargantana_icache_pkg;

    localparam int TAG_WIDHT      = 20;
    localparam int TAG_ADDR_WIDHT = 6;
    localparam int ICACHE_N_WAY   = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        MISS,
        WRITE
    } tag_ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_tag_ctrl_if.sv
// Bundle of lookup, response, refill, flush and tag-way signals around the tag controller.
// master = requester plus tag ways, slave = controller.
interface sargantana_icache_tag_ctrl_if
    import sargantana_icache_pkg::*;
#(
    parameter int NUM_WAYS = ICACHE_N_WAY
) ();

    logic                          lookup_valid_i;
    logic                          lookup_ready_o;
    logic [TAG_ADDR_WIDHT-1:0]     lookup_idx_i;
    logic [TAG_WIDHT-1:0]          lookup_tag_i;
    logic                          resp_valid_o;
    logic                          resp_hit_o;
    logic [NUM_WAYS-1:0]           resp_way_o;
    logic                          refill_valid_i;
    logic                          refill_ready_o;
    logic                          flush_i;
    logic [NUM_WAYS-1:0]           tag_req_o;
    logic                          tag_we_o;
    logic                          tag_vbit_o;
    logic                          tag_flush_o;
    logic [TAG_ADDR_WIDHT-1:0]     tag_addr_o;
    logic [TAG_WIDHT-1:0]          tag_data_o;
    logic [NUM_WAYS*TAG_WIDHT-1:0] tag_rdata_i;
    logic [NUM_WAYS-1:0]           tag_vbit_i;

    modport master (
        output lookup_valid_i, lookup_idx_i, lookup_tag_i, refill_valid_i, flush_i,
        output tag_rdata_i, tag_vbit_i,
        input  lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, refill_ready_o,
        input  tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_addr_o, tag_data_o
    );

    modport slave (
        input  lookup_valid_i, lookup_idx_i, lookup_tag_i, refill_valid_i, flush_i,
        input  tag_rdata_i, tag_vbit_i,
        output lookup_ready_o, resp_valid_o, resp_hit_o, resp_way_o, refill_ready_o,
        output tag_req_o, tag_we_o, tag_vbit_o, tag_flush_o, tag_addr_o, tag_data_o
    );

endinterface

// File: rtl/sargantana_icache_victim_sel.sv
// Victim choice on a miss: lowest-index invalid way, otherwise the round-robin way.
module sargantana_icache_victim_sel #(
    parameter int NUM_WAYS = 4,
    parameter int RR_W     = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] vbit_i,
    input  logic [RR_W-1:0]     rr_i,
    output logic [NUM_WAYS-1:0] victim_o,
    output logic                use_rr_o
);

    logic [NUM_WAYS-1:0] invalid;
    logic [NUM_WAYS-1:0] first_invalid;

    assign invalid       = ~vbit_i;
    // x & -x isolates the lowest set bit, giving a one-hot priority encode.
    assign first_invalid = invalid & (~invalid + NUM_WAYS'(1));
    assign use_rr_o      = &vbit_i;
    assign victim_o      = use_rr_o ? (NUM_WAYS'(1) << rr_i) : first_invalid;

endmodule

// File: rtl/sargantana_icache_tag_ctrl.sv
// Tag lookup / refill sequencer in front of the per-way tag memories.
// Reads all ways, reports hit or victim, and writes the refilled tag into the victim.
module sargantana_icache_tag_ctrl
    import sargantana_icache_pkg::*;
#(
    parameter int NUM_WAYS = ICACHE_N_WAY
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    sargantana_icache_tag_ctrl_if.slave bus
);

    localparam int RR_W = $clog2(NUM_WAYS);

    tag_ctrl_state_t           state_q, state_d;
    logic [RR_W-1:0]           rr_q, rr_d;
    logic [TAG_ADDR_WIDHT-1:0] idx_q, idx_d;
    logic [TAG_WIDHT-1:0]      tag_q, tag_d;
    logic [NUM_WAYS-1:0]       victim_q, victim_d;
    logic                      victim_rr_q, victim_rr_d;
    logic                      resp_valid_q, resp_valid_d;
    logic                      resp_hit_q, resp_hit_d;
    logic [NUM_WAYS-1:0]       resp_way_q, resp_way_d;

    logic [NUM_WAYS-1:0]       hit;
    logic [NUM_WAYS-1:0]       hit_first;
    logic [NUM_WAYS-1:0]       victim;
    logic                      victim_use_rr;

    logic                      lookup_ready;
    logic                      refill_ready;
    logic [NUM_WAYS-1:0]       tag_req;
    logic                      tag_we;
    logic                      tag_vbit;
    logic [TAG_ADDR_WIDHT-1:0] tag_addr;

    for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_hit
        assign hit[gi] = bus.tag_vbit_i[gi] &
                         (bus.tag_rdata_i[gi*TAG_WIDHT +: TAG_WIDHT] == tag_q);
    end

    assign hit_first = hit & (~hit + NUM_WAYS'(1));

    sargantana_icache_victim_sel #(
        .NUM_WAYS (NUM_WAYS),
        .RR_W     (RR_W)
    ) u_victim_sel (
        .vbit_i   (bus.tag_vbit_i),
        .rr_i     (rr_q),
        .victim_o (victim),
        .use_rr_o (victim_use_rr)
    );

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        idx_d        = idx_q;
        tag_d        = tag_q;
        victim_d     = victim_q;
        victim_rr_d  = victim_rr_q;
        resp_valid_d = 1'b0;
        resp_hit_d   = resp_hit_q;
        resp_way_d   = resp_way_q;
        lookup_ready = 1'b0;
        refill_ready = 1'b0;
        tag_req      = '0;
        tag_we       = 1'b0;
        tag_vbit     = 1'b0;
        tag_addr     = (state_q == IDLE) ? bus.lookup_idx_i : idx_q;

        case (state_q)
            IDLE: begin
                lookup_ready = !bus.flush_i;
                if (bus.lookup_valid_i && lookup_ready) begin
                    tag_req = '1;
                    idx_d   = bus.lookup_idx_i;
                    tag_d   = bus.lookup_tag_i;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                resp_valid_d = 1'b1;
                if (|hit) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = hit_first;
                    state_d    = IDLE;
                end else begin
                    resp_hit_d  = 1'b0;
                    resp_way_d  = victim;
                    victim_d    = victim;
                    victim_rr_d = victim_use_rr;
                    state_d     = MISS;
                end
            end
            MISS: begin
                refill_ready = !bus.flush_i;
                if (bus.refill_valid_i && refill_ready) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                tag_req  = victim_q;
                tag_we   = 1'b1;
                tag_vbit = 1'b1;
                // rr only advances when it actually picked the victim.
                if (victim_rr_q) begin
                    rr_d = rr_q + RR_W'(1);
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Flush aborts whatever is in flight and blocks any tag access this cycle.
        if (bus.flush_i) begin
            state_d      = IDLE;
            rr_d         = '0;
            tag_req      = '0;
            tag_we       = 1'b0;
            tag_vbit     = 1'b0;
            resp_valid_d = 1'b0;
            resp_hit_d   = resp_hit_q;
            resp_way_d   = resp_way_q;
            victim_d     = victim_q;
            victim_rr_d  = victim_rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            idx_q        <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            victim_rr_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_way_q   <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            idx_q        <= idx_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            victim_rr_q  <= victim_rr_d;
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_way_q   <= resp_way_d;
        end
    end

    assign bus.lookup_ready_o = lookup_ready;
    assign bus.refill_ready_o = refill_ready;
    assign bus.resp_valid_o   = resp_valid_q;
    assign bus.resp_hit_o     = resp_hit_q;
    assign bus.resp_way_o     = resp_way_q;
    assign bus.tag_req_o      = tag_req;
    assign bus.tag_we_o       = tag_we;
    assign bus.tag_vbit_o     = tag_vbit;
    assign bus.tag_flush_o    = bus.flush_i;
    assign bus.tag_addr_o     = tag_addr;
    assign bus.tag_data_o     = tag_q;

endmodule
